// File: rtl/ifu_iccm_dma_ctl.sv
// ICCM DMA/debug access controller: single outstanding byte..dword request, SECDED per 32b, RMW for sub-word writes.
// Optional: ICCM_DMA_ECC_CORRECT_EN enables single-bit correction; otherwise any nonzero syndrome is reported as error.
`ifndef RV_ICCM_BITS
`define RV_ICCM_BITS 16
`endif

module ifu_iccm_dma_ctl #(
  parameter int ICCM_ADDR_W = `RV_ICCM_BITS
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             req_size,
  input  logic [ICCM_ADDR_W-1:0] req_addr,
  input  logic [63:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [63:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   ecc_sb_err,
  input  logic                   ifu_iccm_busy,
  output logic                   iccm_wren,
  output logic                   iccm_rden,
  output logic [ICCM_ADDR_W-3:0] iccm_rw_addr,
  output logic [2:0]             iccm_wr_size,
  output logic [77:0]            iccm_wr_data,
  input  logic [155:0]           iccm_rd_data
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE_RD = 3'd1;
  localparam logic [2:0] CAPTURE  = 3'd2;
  localparam logic [2:0] ISSUE_WR = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

`ifdef ICCM_DMA_ECC_CORRECT_EN
  localparam logic ECC_FIX = 1'b1;
`else
  localparam logic ECC_FIX = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        sb;
    logic        db;
  } dec_t;

  // Hamming check bits: data occupies the non-power-of-two positions 3..38.
  function automatic logic [5:0] ham6(input logic [31:0] d);
    logic [5:0] h;
    logic [5:0] pos;
    int         k;
    h = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      pos = 6'(p);
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        for (int i = 0; i < 6; i++)
          if (pos[i]) h[i] = h[i] ^ d[k];
        k++;
      end
    end
    return h;
  endfunction

  function automatic logic [38:0] ecc_enc(input logic [31:0] d);
    logic [5:0] h;
    h = ham6(d);
    return {^{d, h}, h, d};
  endfunction

  function automatic dec_t ecc_dec(input logic [38:0] cw, input logic fix);
    dec_t       r;
    logic [5:0] syn;
    logic [5:0] pos;
    logic       par;
    int         k;
    syn    = ham6(cw[31:0]) ^ cw[37:32];
    par    = ^cw;
    r.data = cw[31:0];
    r.sb   = par;
    r.db   = !par && (syn != 6'd0);
    k      = 0;
    for (int p = 1; p <= 38; p++) begin
      pos = 6'(p);
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        if (fix && par && (pos == syn)) r.data[k] = ~r.data[k];
        k++;
      end
    end
    return r;
  endfunction

  logic [2:0]             state;
  logic                   write_q;
  logic [1:0]             size_q;
  logic [ICCM_ADDR_W-1:0] addr_q;
  logic [15:0]            wdata_q;
  logic                   err_q;
  logic                   sb_q;
  logic [63:0]            rdata_q;
  logic [77:0]            wr_data_q;

  logic        misalign;
  logic [38:0] cw_lo, cw_hi, cw0, cw1, merged_cw;
  logic [77:0] half;
  dec_t        dec0, dec1;
  logic        use1, sb_any, db_any, cap_err;
  logic [31:0] merged;
  logic [63:0] rd_sel;

  always_comb begin
    misalign = req_size[2]
             | ((req_size[1:0] == 2'd1) & req_addr[0])
             | ((req_size[1:0] == 2'd2) & (|req_addr[1:0]))
             | ((req_size[1:0] == 2'd3) & (|req_addr[2:0]));
    cw_lo = ecc_enc(req_wdata[31:0]);
    cw_hi = ecc_enc(req_wdata[63:32]);
  end

  // addr[3] picks the 78b half of the row; addr[2] picks the codeword (dword is 8B aligned, so cw0 is the low word).
  always_comb begin
    half    = addr_q[3] ? iccm_rd_data[155:78] : iccm_rd_data[77:0];
    cw0     = addr_q[2] ? half[77:39] : half[38:0];
    cw1     = half[77:39];
    dec0    = ecc_dec(cw0, ECC_FIX);
    dec1    = ecc_dec(cw1, ECC_FIX);
    use1    = (size_q == 2'd3);
    sb_any  = dec0.sb | (use1 & dec1.sb);
    db_any  = dec0.db | (use1 & dec1.db);
    cap_err = db_any | (!ECC_FIX & sb_any);
    merged  = dec0.data;
    if (size_q == 2'd0) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    merged_cw = ecc_enc(merged);
    case (size_q)
      2'd0:    rd_sel = {56'd0, dec0.data[{addr_q[1:0], 3'b000} +: 8]};
      2'd1:    rd_sel = {48'd0, dec0.data[{addr_q[1], 4'b0000} +: 16]};
      2'd2:    rd_sel = {32'd0, dec0.data};
      default: rd_sel = {dec1.data, dec0.data};
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      sb_q      <= 1'b0;
      rdata_q   <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          write_q   <= req_write;
          size_q    <= req_size[1:0];
          addr_q    <= req_addr;
          wdata_q   <= req_wdata[15:0];
          err_q     <= misalign;
          sb_q      <= 1'b0;
          rdata_q   <= '0;
          wr_data_q <= (req_size[1:0] == 2'd3) ? {cw_hi, cw_lo} : {cw_lo, cw_lo};
          if (misalign)                     state <= RESP;
          else if (req_write && req_size[1]) state <= ISSUE_WR;
          else                              state <= ISSUE_RD;
        end
        ISSUE_RD: if (!ifu_iccm_busy) state <= CAPTURE;
        CAPTURE: begin
          err_q <= cap_err;
          sb_q  <= ECC_FIX & sb_any;
          if (write_q) begin
            wr_data_q <= {merged_cw, merged_cw};
            state     <= cap_err ? RESP : ISSUE_WR;
          end else begin
            rdata_q <= rd_sel;
            state   <= RESP;
          end
        end
        ISSUE_WR: if (!ifu_iccm_busy) state <= RESP;
        RESP:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state == IDLE);
  assign iccm_rden    = (state == ISSUE_RD) & !ifu_iccm_busy;
  assign iccm_wren    = (state == ISSUE_WR) & !ifu_iccm_busy;
  assign iccm_wr_size = (state != ISSUE_WR) ? 3'd0 : ((size_q == 2'd3) ? 3'd3 : 3'd2);
  assign iccm_rw_addr = addr_q[ICCM_ADDR_W-1:2];
  assign iccm_wr_data = wr_data_q;
  assign rsp_valid    = (state == RESP);
  assign rsp_err      = rsp_valid & err_q;
  assign rsp_rdata    = rsp_valid ? rdata_q : 64'd0;
  assign ecc_sb_err   = rsp_valid & sb_q;

endmodule

// File: tb/tb_ifu_iccm_dma_ctl.sv
// Directed bench for ifu_iccm_dma_ctl with a behavioural ICCM array model and independent SECDED encoder.
module tb_ifu_iccm_dma_ctl;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, ifu_iccm_busy = 1'b0;
  logic [2:0]    req_size = '0;
  logic [AW-1:0] req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, ecc_sb_err, iccm_wren, iccm_rden;
  logic [63:0]   rsp_rdata;
  logic [AW-3:0] iccm_rw_addr;
  logic [2:0]    iccm_wr_size;
  logic [77:0]   iccm_wr_data;
  logic [155:0]  iccm_rd_data = '0;

  ifu_iccm_dma_ctl #(.ICCM_ADDR_W(AW)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ecc_sb_err(ecc_sb_err),
    .ifu_iccm_busy(ifu_iccm_busy), .iccm_wren(iccm_wren), .iccm_rden(iccm_rden),
    .iccm_rw_addr(iccm_rw_addr), .iccm_wr_size(iccm_wr_size), .iccm_wr_data(iccm_wr_data),
    .iccm_rd_data(iccm_rd_data)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0, cyc = 0;
  int bad_cnt = 0, wren_cnt = 0;
  logic [38:0] mem [0:(1<<(AW-2))-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Array model: read row returned the cycle after rden; word writes take the codeword for the addressed slot.
  always @(posedge clk) begin
    if (iccm_rden)
      iccm_rd_data <= {mem[{iccm_rw_addr[AW-3:2], 2'd3}], mem[{iccm_rw_addr[AW-3:2], 2'd2}],
                       mem[{iccm_rw_addr[AW-3:2], 2'd1}], mem[{iccm_rw_addr[AW-3:2], 2'd0}]};
    if (iccm_wren) begin
      wren_cnt <= wren_cnt + 1;
      if (iccm_wr_size == 3'd3) begin
        mem[{iccm_rw_addr[AW-3:1], 1'b0}] <= iccm_wr_data[38:0];
        mem[{iccm_rw_addr[AW-3:1], 1'b1}] <= iccm_wr_data[77:39];
      end else
        mem[iccm_rw_addr] <= iccm_rw_addr[0] ? iccm_wr_data[77:39] : iccm_wr_data[38:0];
    end
    if (rst_l && ((iccm_wren && iccm_rden) || (ifu_iccm_busy && (iccm_wren || iccm_rden))))
      bad_cnt <= bad_cnt + 1;
  end

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] pos;
    logic [5:0]  h;
    int          k;
    pos = '0;
    k   = 0;
    for (int p = 1; p <= 38; p++)
      if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
        pos[p] = d[k];
        k++;
      end
    for (int i = 0; i < 6; i++) begin
      h[i] = 1'b0;
      for (int p = 1; p <= 38; p++) if (((p >> i) & 1) == 1) h[i] = h[i] ^ pos[p];
    end
    return {^{d, h}, h, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  logic [63:0] r_data;
  logic        r_err, r_sb, r_seen;
  int          t_rd, t_wr, t_rsp;
  logic [77:0] wd_cap;
  logic [2:0]  ws_cap;

  // Times are cycles after the accept cycle; -1 means the event never occurred.
  task automatic do_req(input logic wr, input logic [2:0] sz, input logic [AW-1:0] a,
                        input logic [63:0] wd, input int bfrom, input int blen);
    t_rd = -1; t_wr = -1; t_rsp = -1; r_seen = 1'b0;
    r_data = '0; r_err = 1'b0; r_sb = 1'b0; wd_cap = '0; ws_cap = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd; ifu_iccm_busy = 1'b0;
    #1;
    for (int n = 1; n <= 40 && !r_seen; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      ifu_iccm_busy = (n >= bfrom) && (n < bfrom + blen);
      #1;
      if (iccm_rden && t_rd < 0) t_rd = n;
      if (iccm_wren) begin t_wr = n; wd_cap = iccm_wr_data; ws_cap = iccm_wr_size; end
      if (rsp_valid) begin
        t_rsp = n; r_data = rsp_rdata; r_err = rsp_err; r_sb = ecc_sb_err; r_seen = 1'b1;
      end
    end
    ifu_iccm_busy = 1'b0;
    chk("rsp_seen", {63'd0, r_seen}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] <= '0;
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_outs", {60'd0, rsp_valid, rsp_err, iccm_wren, iccm_rden}, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;

    do_req(1'b1, 3'd3, 16'h0010, 64'h1122334455667788, 0, 0);
    chk("dw_wr_twren", 64'(t_wr), 64'd1);
    chk("dw_wr_size", {61'd0, ws_cap}, 64'd3);
    chk("dw_wr_hi", {25'd0, wd_cap[77:39]}, {25'd0, enc(32'h11223344)});
    chk("dw_wr_trsp", 64'(t_rsp), 64'd2);
    chk("dw_wr_trd", 64'(t_rd), -64'sd1);

    do_req(1'b0, 3'd3, 16'h0010, 64'h0, 0, 0);
    chk("dw_rd_trd", 64'(t_rd), 64'd1);
    chk("dw_rd_trsp", 64'(t_rsp), 64'd3);
    chk("dw_rd_data", r_data, 64'h1122334455667788);
    chk("dw_rd_err", {63'd0, r_err}, 64'd0);

    do_req(1'b0, 3'd1, 16'h0012, 64'h0, 0, 0);
    chk("half_rd", r_data, 64'h5566);
    do_req(1'b0, 3'd0, 16'h0017, 64'h0, 0, 0);
    chk("byte_rd", r_data, 64'h11);

    do_req(1'b1, 3'd0, 16'h0021, 64'hAB, 0, 0);
    chk("rmw_trd", 64'(t_rd), 64'd1);
    chk("rmw_twr", 64'(t_wr), 64'd3);
    chk("rmw_trsp", 64'(t_rsp), 64'd4);
    chk("rmw_size", {61'd0, ws_cap}, 64'd2);
    chk("rmw_cw", {25'd0, wd_cap[38:0]}, {25'd0, enc(32'h0000AB00)});
    chk("rmw_repl", {25'd0, wd_cap[77:39]}, {25'd0, enc(32'h0000AB00)});
    do_req(1'b0, 3'd2, 16'h0020, 64'h0, 0, 0);
    chk("rmw_readback", r_data, 64'h0000AB00);

    do_req(1'b0, 3'd2, 16'h0002, 64'h0, 0, 0);
    chk("mis_trsp", 64'(t_rsp), 64'd1);
    chk("mis_err", {63'd0, r_err}, 64'd1);
    chk("mis_noacc", {32'(t_rd), 32'(t_wr)}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    do_req(1'b0, 3'd6, 16'h0010, 64'h0, 0, 0);
    chk("sz2_err", {63'd0, r_err}, 64'd1);

    do_req(1'b0, 3'd2, 16'h0014, 64'h0, 1, 3);
    chk("busy_trd", 64'(t_rd), 64'd4);
    chk("busy_trsp", 64'(t_rsp), 64'd6);
    chk("busy_data", r_data, 64'h11223344);

    do_req(1'b1, 3'd2, 16'h0030, 64'hDEADBEEF, 0, 0);
    chk("wd_wr_size", {61'd0, ws_cap}, 64'd2);
    @(negedge clk);
    mem[12] <= mem[12] ^ 39'h20;
    do_req(1'b0, 3'd2, 16'h0030, 64'h0, 0, 0);
`ifdef ICCM_DMA_ECC_CORRECT_EN
    chk("sb_data", r_data, 64'hDEADBEEF);
    chk("sb_flag", {62'd0, r_err, r_sb}, 64'd1);
`else
    chk("sb_data", r_data, 64'hDEADBECF);
    chk("sb_flag", {62'd0, r_err, r_sb}, 64'd2);
`endif

    do_req(1'b1, 3'd2, 16'h0040, 64'h12345678, 0, 0);
    @(negedge clk);
    mem[16] <= mem[16] ^ 39'h201;
    do_req(1'b1, 3'd1, 16'h0042, 64'hBEEF, 0, 0);
    chk("db_nowr", 64'(t_wr), -64'sd1);
    chk("db_err", {63'd0, r_err}, 64'd1);
    chk("db_mem", {25'd0, mem[16]}, {25'd0, enc(32'h12345678) ^ 39'h201});

    // Reset lands while the RMW sits in CAPTURE; the pending write must never reach the array.
    do_req(1'b1, 3'd2, 16'h0050, 64'h0BADF00D, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 3'd1; req_addr = 16'h0050; req_wdata = 64'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rr_rden", {63'd0, iccm_rden}, 64'd1);
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("rr_ready", {63'd0, req_ready}, 64'd1);
    chk("rr_outs", {60'd0, rsp_valid, rsp_err, iccm_wren, iccm_rden}, 64'd0);
    @(negedge clk);
    rst_l = 1'b1;
    begin
      int wc0;
      logic seen;
      wc0 = wren_cnt;
      seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        #1;
        if (rsp_valid) seen = 1'b1;
      end
      chk("rr_norsp", {63'd0, seen}, 64'd0);
      chk("rr_nowr", 64'(wren_cnt - wc0), 64'd0);
    end
    chk("rr_mem", {25'd0, mem[20]}, {25'd0, enc(32'h0BADF00D)});

    chk("no_overlap", 64'(bad_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
